uart_mmio_responder: RTL and testbench
======================================

UART_MMIO_RESPONDER -- requirements
Module: uart_mmio_responder

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, entries per TX and RX FIFO (power of two, at least 2).
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Address, input, 32 bits: CPU data address.
REQ-005 The block SHALL have port WriteData, input, 32 bits: CPU store data.
REQ-006 The block SHALL have port REUART, input, 1 bit: CPU load strobe for I/O space.
REQ-007 The block SHALL have port WEUART, input, 1 bit: CPU store strobe for I/O space.
REQ-008 The block SHALL have port ReadData, output, 32 bits: registered load result.
REQ-009 The block SHALL have port TxData, output, 8 bits: byte offered to the serial transmitter.
REQ-010 The block SHALL have port TxValid, output, 1 bit: TxData valid.
REQ-011 The block SHALL have port TxReady, input, 1 bit: transmitter accepts TxData.
REQ-012 The block SHALL have port RxData, input, 8 bits: byte from the serial receiver.
REQ-013 The block SHALL have port RxValid, input, 1 bit: RxData valid.
REQ-014 The block SHALL have port RxReady, output, 1 bit: block accepts RxData.

Function
REQ-015 A CPU access SHALL be decoded only when Address[31:28]=4'b1000; the offset is Address[4:0]. Accesses to any other region SHALL be ignored.
REQ-016 The register map SHALL be:
- 0x00 TX status: bit0 = TX FIFO not full; bit1 = sticky TX overflow.
- 0x04 RX status: bit0 = RX FIFO not empty; bit1 = sticky RX underflow.
- 0x08 TX data: write only.
- 0x0C RX data: read pops.
- 0x10 cycle counter.
- Other offsets SHALL read 0 and ignore writes.
REQ-017 Load latency SHALL be one cycle: ReadData is updated on the edge where REUART=1 and holds its value until the next decoded read.
REQ-018 A write to 0x08 with the TX FIFO not full at the start of the cycle SHALL push WriteData[7:0]. When the FIFO is full, the byte SHALL be dropped and TX overflow set. There is no same-cycle bypass through a pop.
REQ-019 TX side: TxValid SHALL equal "TX FIFO not empty" and TxData SHALL be the head byte. A pop SHALL occur when TxValid && TxReady. A simultaneous push and pop SHALL leave the count unchanged.
REQ-020 RX side: RxReady SHALL equal "RX FIFO not full". A push SHALL occur when RxValid && RxReady.
REQ-021 A read of 0x0C with the RX FIFO non-empty SHALL return {24'b0, head} and pop. On an empty FIFO it SHALL return 0, leave the FIFO unchanged, and set RX underflow.
REQ-022 A simultaneous RX push and CPU pop SHALL both take effect. The popped byte SHALL be the pre-push head.
REQ-023 Status bit0 SHALL reflect FIFO state at the start of the read cycle.
REQ-024 A write to 0x00 SHALL clear TX overflow; a write to 0x04 SHALL clear RX underflow. A set and a clear in the same cycle SHALL result in set.
REQ-025 The cycle counter SHALL be 32 bits, increment every cycle, and wrap from 0xFFFFFFFF to 0. A write to 0x10 SHALL load 0 on that edge.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with a count of width clog2(FIFO_DEPTH)+1.
REQ-027 REUART and WEUART asserted in the same cycle SHALL be treated as both a read and a write to Address.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously set: ReadData=0, both FIFOs empty (TxValid=0, RxReady=1), sticky flags=0, cycle counter=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents. The cycle after deassertion SHALL behave as a fresh reset.

Verification
REQ-030 The bench SHALL check reset: reset_n=0 -> ReadData=0, TxValid=0, RxReady=1; one cycle after release, a read of 0x80000010 returns 0x00000000.
REQ-031 The bench SHALL check TX fill: with TxReady=0, write 0x41..0x45 to 0x80000008 -> 0x80000000 reads 0x2; after release of TxReady, TxData sequence is 0x41,0x42,0x43,0x44 and then TxValid=0.
REQ-032 The bench SHALL check RX: drive RxData 0x55,0xAA with RxValid -> reads of 0x80000004 = 0x1, then 0x8000000C = 0x55, then 0x8000000C = 0xAA; a third read returns 0, and 0x80000004 then reads 0x2.
REQ-033 The bench SHALL check concurrency: with the RX FIFO full (RxReady=0), a CPU read of 0x8000000C in the same cycle as RxValid -> returns the oldest byte, RxReady=1 on the next cycle, and the new byte is not accepted.
REQ-034 The bench SHALL check flag clear and counter: write 0x80000000 -> the next read returns bit1=0; write 0x80000010, then read 3 cycles later -> value 0x3 (counted from the write edge to the read edge).
REQ-035 The bench SHALL check decode: a store to 0x10000008 (data memory) -> no TX push, TxValid unchanged.

Source files
------------

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART front end: CPU-visible status/data/counter registers in front of
// a TX byte FIFO feeding the serial transmitter and an RX byte FIFO fed by the receiver.
module uart_mmio_responder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        REUART,
    input  logic        WEUART,
    output logic [31:0] ReadData,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = '0;

    localparam logic [4:0] OFF_TX_STAT = 5'h00;
    localparam logic [4:0] OFF_RX_STAT = 5'h04;
    localparam logic [4:0] OFF_TX_DATA = 5'h08;
    localparam logic [4:0] OFF_RX_DATA = 5'h0C;
    localparam logic [4:0] OFF_CYCLE   = 5'h10;

    // Address decode
    logic       io_sel;
    logic [4:0] offset;
    logic       rd_en;
    logic       wr_en;

    assign io_sel = (Address[31:28] == 4'b1000);
    assign offset = Address[4:0];
    assign rd_en  = REUART && io_sel;
    assign wr_en  = WEUART && io_sel;

    logic unused_bits;
    assign unused_bits = ^{Address[27:5], WriteData[31:8]};

    // TX FIFO state
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] tx_count_q,  tx_count_d;
    logic          tx_full, tx_empty;
    logic          tx_push, tx_pop;
    logic          tx_ovf_q, tx_ovf_d;

    // RX FIFO state
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0] rx_count_q,  rx_count_d;
    logic          rx_full, rx_empty;
    logic          rx_push, rx_pop;
    logic          rx_udf_q, rx_udf_d;

    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   read_data_q, read_data_d;

    assign tx_full  = (tx_count_q == CNT_FULL);
    assign tx_empty = (tx_count_q == CNT_EMPTY);
    assign rx_full  = (rx_count_q == CNT_FULL);
    assign rx_empty = (rx_count_q == CNT_EMPTY);

    // Handshake: a byte moves on an edge where valid && ready are both high.
    assign TxValid  = !tx_empty;
    assign TxData   = tx_mem_q[tx_rd_ptr_q];
    assign RxReady  = !rx_full;
    assign ReadData = read_data_q;

    assign tx_push = wr_en && (offset == OFF_TX_DATA) && !tx_full;
    assign tx_pop  = TxValid && TxReady;
    assign rx_push = RxValid && RxReady;
    assign rx_pop  = rd_en && (offset == OFF_RX_DATA) && !rx_empty;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_count_d  = tx_count_q;
        if (tx_push) begin
            tx_wr_ptr_d = tx_wr_ptr_q + PTR_ONE;
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PTR_ONE;
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
    end

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_count_d  = rx_count_q;
        if (rx_push) begin
            rx_wr_ptr_d = rx_wr_ptr_q + PTR_ONE;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PTR_ONE;
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
    end

    // Sticky flags: clear is applied first so a same-cycle set wins.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_udf_d = rx_udf_q;
        if (wr_en && (offset == OFF_TX_STAT)) begin
            tx_ovf_d = 1'b0;
        end
        if (wr_en && (offset == OFF_RX_STAT)) begin
            rx_udf_d = 1'b0;
        end
        if (wr_en && (offset == OFF_TX_DATA) && tx_full) begin
            tx_ovf_d = 1'b1;
        end
        if (rd_en && (offset == OFF_RX_DATA) && rx_empty) begin
            rx_udf_d = 1'b1;
        end
    end

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_en && (offset == OFF_CYCLE)) begin
            cycle_d = 32'd0;
        end
    end

    always_comb begin
        read_data_d = read_data_q;
        if (rd_en) begin
            case (offset)
                OFF_TX_STAT: read_data_d = {30'b0, tx_ovf_q, !tx_full};
                OFF_RX_STAT: read_data_d = {30'b0, rx_udf_q, !rx_empty};
                OFF_RX_DATA: read_data_d = rx_empty ? 32'd0 : {24'b0, rx_mem_q[rx_rd_ptr_q]};
                OFF_CYCLE:   read_data_d = cycle_q;
                default:     read_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            tx_ovf_q    <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rx_udf_q    <= 1'b0;
            cycle_q     <= 32'd0;
            read_data_q <= 32'd0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            rx_udf_q    <= rx_udf_d;
            cycle_q     <= cycle_d;
            read_data_q <= read_data_d;
        end
    end

    // Storage needs no reset: empty FIFOs never expose their contents.
    always_ff @(posedge Clock) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= WriteData[7:0];
        end
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= RxData;
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder: expected load results and TX bytes are queued
// by the drivers and checked by an independent monitor as the DUT presents them.
module tb_uart_mmio_responder;

  logic        Clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        REUART = 1'b0;
  logic        WEUART = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic [7:0]  RxData = 8'd0;
  logic        RxValid = 1'b0;
  logic        RxReady;

  uart_mmio_responder #(.FIFO_DEPTH(4)) dut (
    .Clock     (Clock),
    .reset_n   (reset_n),
    .Address   (Address),
    .WriteData (WriteData),
    .REUART    (REUART),
    .WEUART    (WEUART),
    .ReadData  (ReadData),
    .TxData    (TxData),
    .TxValid   (TxValid),
    .TxReady   (TxReady),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        rd_pending = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: a load result is visible the half cycle after its read edge,
  // and a TX byte is checked while valid && ready are both high.
  always @(posedge Clock) rd_pending <= REUART;

  always @(negedge Clock) begin
    if (rd_pending) begin
      if (rd_exp_q.size() == 0) begin
        check32("unexpected_read", ReadData, 32'hDEAD_BEEF);
      end else begin
        check32("read_data", ReadData, rd_exp_q.pop_front());
      end
    end
    if (TxValid && TxReady) begin
      if (tx_exp_q.size() == 0) begin
        check32("unexpected_tx", {24'd0, TxData}, 32'hDEAD_BEEF);
      end else begin
        check32("tx_data", {24'd0, TxData}, {24'd0, tx_exp_q.pop_front()});
      end
    end
  end

  // driver tasks: each is entered 1 time unit after a rising edge and consumes one edge
  task automatic cpu_read(input logic [31:0] addr, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    Address = addr;
    REUART  = 1'b1;
    @(posedge Clock); #1;
    REUART  = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    WEUART    = 1'b1;
    @(posedge Clock); #1;
    WEUART    = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    RxData  = b;
    RxValid = 1'b1;
    @(posedge Clock); #1;
    RxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    // reset values while reset_n is low
    #12;
    check32("rst_read_data", ReadData, 32'd0);
    check32("rst_tx_valid", {31'd0, TxValid}, 32'd0);
    check32("rst_rx_ready", {31'd0, RxReady}, 32'd1);
    @(posedge Clock); #1;
    reset_n = 1'b1;
    cpu_read(32'h8000_0010, 32'h0000_0000);

    // TX fill with transmitter stalled: fifth byte overflows
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_exp_q.push_back(8'(8'h41 + i));
      cpu_write(32'h8000_0008, 32'h0000_0041 + i);
    end
    cpu_read(32'h8000_0000, 32'h0000_0002);
    TxReady = 1'b1;
    for (int i = 0; i < 20 && tx_exp_q.size() != 0; i++) @(posedge Clock);
    #1;
    check32("tx_drain_left", tx_exp_q.size(), 0);
    check32("tx_valid_after_drain", {31'd0, TxValid}, 32'd0);

    // RX path and underflow
    rx_send(8'h55);
    rx_send(8'hAA);
    cpu_read(32'h8000_0004, 32'h0000_0001);
    cpu_read(32'h8000_000C, 32'h0000_0055);
    cpu_read(32'h8000_000C, 32'h0000_00AA);
    cpu_read(32'h8000_000C, 32'h0000_0000);
    cpu_read(32'h8000_0004, 32'h0000_0002);
    cpu_write(32'h8000_0004, 32'h0);
    cpu_read(32'h8000_0004, 32'h0000_0000);

    // full RX FIFO: CPU pop and refused RxValid in the same cycle
    for (int i = 0; i < 4; i++) rx_send(8'(8'h10 + i));
    check32("rx_ready_full", {31'd0, RxReady}, 32'd0);
    rd_exp_q.push_back(32'h0000_0010);
    Address = 32'h8000_000C;
    REUART  = 1'b1;
    RxData  = 8'h99;
    RxValid = 1'b1;
    @(posedge Clock); #1;
    REUART  = 1'b0;
    RxValid = 1'b0;
    check32("rx_ready_after_pop", {31'd0, RxReady}, 32'd1);
    cpu_read(32'h8000_000C, 32'h0000_0011);
    cpu_read(32'h8000_000C, 32'h0000_0012);
    cpu_read(32'h8000_000C, 32'h0000_0013);
    cpu_read(32'h8000_000C, 32'h0000_0000);
    cpu_write(32'h8000_0004, 32'h0);

    // TX overflow clear; empty TX FIFO reads not-full
    cpu_write(32'h8000_0000, 32'h0);
    cpu_read(32'h8000_0000, 32'h0000_0001);

    // counter cleared on the write edge, then three idle edges before the read edge
    cpu_write(32'h8000_0010, 32'hFFFF_FFFF);
    idle(3);
    cpu_read(32'h8000_0010, 32'h0000_0003);

    // unrelated region and unmapped offset
    cpu_write(32'h1000_0008, 32'h0000_0066);
    check32("decode_tx_valid", {31'd0, TxValid}, 32'd0);
    cpu_read(32'h8000_0014, 32'h0000_0000);

    // reset in mid-operation discards queued data
    TxReady = 1'b0;
    cpu_write(32'h8000_0008, 32'h0000_0077);
    rx_send(8'h31);
    check32("pre_rst_tx_valid", {31'd0, TxValid}, 32'd1);
    reset_n = 1'b0;
    #2;
    check32("mid_rst_tx_valid", {31'd0, TxValid}, 32'd0);
    check32("mid_rst_rx_ready", {31'd0, RxReady}, 32'd1);
    check32("mid_rst_read_data", ReadData, 32'd0);
    @(posedge Clock); #1;
    reset_n = 1'b1;
    cpu_read(32'h8000_0004, 32'h0000_0000);
    cpu_read(32'h8000_0000, 32'h0000_0001);

    idle(3);
    check32("rd_queue_left", rd_exp_q.size(), 0);
    check32("tx_queue_left", tx_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
